// File: rtl/sram_1rw_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro.
// After reset the whole macro is cleared to zero before any request is accepted.
module sram_1rw_arbiter #(
    parameter int BITS       = 15,
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_DEPTH = 4096
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [BITS-1:0]       req0_wdata,
    input  logic [BITS-1:0]       req0_wmask,
    output logic                  rsp0_valid,
    output logic [BITS-1:0]       rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [BITS-1:0]       req1_wdata,
    input  logic [BITS-1:0]       req1_wmask,
    output logic                  rsp1_valid,
    output logic [BITS-1:0]       rsp1_rdata,

    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd,

    output logic                  init_done
);

    // Handshake: a request transfers in any cycle where reqN_valid && reqN_ready;
    // ready is combinational from both valids, so a requester must not wait on it.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  prio;      // 0: port 0 wins a tie, 1: port 1 wins
    logic                  pend0;
    logic                  pend1;
    logic                  in_run;
    logic                  init_active;
    logic                  gnt0;
    logic                  gnt1;

    assign in_run      = (state == ST_RUN);
    assign init_active = (state == ST_INIT) && !reset;
    assign init_done   = in_run;

    assign gnt0 = in_run && req0_valid && (!req1_valid || !prio);
    assign gnt1 = in_run && req1_valid && (!req0_valid ||  prio);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wd    = '0;
        sram_wmask = '0;
        if (init_active) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = clr_cnt;
            sram_wmask = '1;
        end else if (gnt0) begin
            sram_ce    = 1'b1;
            sram_we    = req0_we;
            sram_addr  = req0_addr;
            sram_wd    = req0_wdata;
            sram_wmask = req0_wmask;
        end else if (gnt1) begin
            sram_ce    = 1'b1;
            sram_we    = req1_we;
            sram_addr  = req1_addr;
            sram_wd    = req1_wdata;
            sram_wmask = req1_wmask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
            prio    <= 1'b0;
            pend0   <= 1'b0;
            pend1   <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                clr_cnt <= clr_cnt + ONE;
                if (clr_cnt == LAST_ADDR) begin
                    state <= ST_RUN;
                end
            end
            pend0 <= gnt0 && !req0_we;
            pend1 <= gnt1 && !req1_we;
            if (gnt0) begin
                prio <= 1'b1;
            end else if (gnt1) begin
                prio <= 1'b0;
            end
        end
    end

    // Macro read data arrives the cycle after the access; pass it straight through.
    assign rsp0_valid = pend0;
    assign rsp1_valid = pend1;
    assign rsp0_rdata = pend0 ? sram_rd : '0;
    assign rsp1_rdata = pend1 ? sram_rd : '0;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter with a behavioural masked-write SRAM macro.
module tb_sram_1rw_arbiter;

    localparam int BITS = 15;
    localparam int AW   = 12;
    localparam int WD   = 4096;

    logic            clk;
    logic            reset;
    logic            req0_valid, req0_ready, req0_we;
    logic [AW-1:0]   req0_addr;
    logic [BITS-1:0] req0_wdata, req0_wmask;
    logic            rsp0_valid;
    logic [BITS-1:0] rsp0_rdata;
    logic            req1_valid, req1_ready, req1_we;
    logic [AW-1:0]   req1_addr;
    logic [BITS-1:0] req1_wdata, req1_wmask;
    logic            rsp1_valid;
    logic [BITS-1:0] rsp1_rdata;
    logic            sram_ce, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [BITS-1:0] sram_wd, sram_wmask, sram_rd;
    logic            init_done;

    int checks;
    int errors;

    logic [BITS-1:0] mem [0:WD-1];
    logic [BITS-1:0] rd_q;

    sram_1rw_arbiter #(.BITS(BITS), .ADDR_WIDTH(AW), .WORD_DEPTH(WD)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wd(sram_wd), .sram_wmask(sram_wmask), .sram_rd(sram_rd),
        .init_done(init_done)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural macro: masked write, registered read data.
    initial begin
        for (int i = 0; i < WD; i++) mem[i] = BITS'($urandom);
        rd_q = '0;
    end

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
            else         rd_q <= mem[sram_addr];
        end
    end
    assign sram_rd = rd_q;

    // Driver tasks
    task automatic idle_inputs();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [BITS-1:0] d, input logic [BITS-1:0] m);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_wmask = m;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [BITS-1:0] d, input logic [BITS-1:0] m);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_wmask = m;
    endtask

    // Each window starts at a falling edge; inputs change there, outputs are sampled 1ns later.
    task automatic next_window();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        req0_valid = 1; req1_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, sram_ce} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got r0=%b r1=%b v0=%b v1=%b done=%b ce=%b, need all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, sram_ce);
        end
    endtask

    task automatic run_init(input string tag);
        int bad;
        bad = 0;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < WD; i++) begin
            #1;
            checks++;
            if ({sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, req0_ready, req1_ready, init_done}
                !== {1'b1, 1'b1, AW'(i), {BITS{1'b0}}, {BITS{1'b1}}, 3'b000}) begin
                errors++;
                if (bad < 5)
                    $display("FAIL %s_cycle%0d: ce=%b we=%b addr=%h wd=%h mask=%h r0=%b r1=%b done=%b, need 1 1 %h 0 7fff 0 0 0",
                             tag, i, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask,
                             req0_ready, req1_ready, init_done, AW'(i));
                bad++;
            end
            next_window();
        end
        idle_inputs();
        #1;
        checks++;
        if ({init_done, sram_ce, sram_we} !== 3'b100) begin
            errors++;
            $display("FAIL %s_done: done=%b ce=%b we=%b, need 1 0 0", tag, init_done, sram_ce, sram_we);
        end
        next_window();
    endtask

    task automatic test_init();
        @(negedge clk);
        reset = 1'b0;
        run_init("init");
    endtask

    task automatic test_write_read();
        drive0(1, 1, 12'h123, 15'h5A5A, 15'h7FFF);
        #1;
        checks++;
        if ({req0_ready, req1_ready, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask}
            !== {4'b1011, 12'h123, 15'h5A5A, 15'h7FFF}) begin
            errors++;
            $display("FAIL wr_grant: r0=%b r1=%b ce=%b we=%b addr=%h wd=%h m=%h, need 1 0 1 1 123 5a5a 7fff",
                     req0_ready, req1_ready, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask);
        end
        next_window();
        drive0(1, 0, 12'h123, 15'h0, 15'h0);
        #1;
        checks++;
        if ({req0_ready, sram_ce, sram_we, sram_addr, rsp0_valid, rsp1_valid} !== {3'b110, 12'h123, 2'b00}) begin
            errors++;
            $display("FAIL rd_grant: r0=%b ce=%b we=%b addr=%h v0=%b v1=%b, need 1 1 0 123 0 0",
                     req0_ready, sram_ce, sram_we, sram_addr, rsp0_valid, rsp1_valid);
        end
        next_window();
        idle_inputs();
        #1;
        checks++;
        if ({rsp0_valid, rsp0_rdata, rsp1_valid, sram_ce, sram_we} !== {1'b1, 15'h5A5A, 3'b000}) begin
            errors++;
            $display("FAIL rd_rsp: v0=%b d0=%h v1=%b ce=%b we=%b, need 1 5a5a 0 0 0",
                     rsp0_valid, rsp0_rdata, rsp1_valid, sram_ce, sram_we);
        end
        next_window();
        #1;
        checks++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b0, 15'h0}) begin
            errors++;
            $display("FAIL rd_pulse_end: v0=%b d0=%h, need 0 0000", rsp0_valid, rsp0_rdata);
        end
        next_window();
    endtask

    task automatic test_masked_write();
        drive1(1, 1, 12'h005, 15'h7FFF, 15'h7FFF);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mask_wr1: r1=%b r0=%b, need 1 0", req1_ready, req0_ready);
        end
        next_window();
        drive1(1, 1, 12'h005, 15'h0000, 15'h00FF);
        next_window();
        drive1(1, 0, 12'h005, 15'h0, 15'h0);
        next_window();
        idle_inputs();
        #1;
        checks++;
        if ({rsp1_valid, rsp1_rdata, rsp0_valid} !== {1'b1, 15'h7F00, 1'b0}) begin
            errors++;
            $display("FAIL mask_rsp: v1=%b d1=%h v0=%b, need 1 7f00 0", rsp1_valid, rsp1_rdata, rsp0_valid);
        end
        next_window();
    endtask

    // Pointer sits at port 0 after the last port-1 grant; a lone port-1 request still wins at once.
    task automatic test_port1_only();
        drive1(1, 0, 12'h005, 15'h0, 15'h0);
        #1;
        checks++;
        if ({req0_ready, req1_ready, sram_ce, sram_addr} !== {3'b011, 12'h005}) begin
            errors++;
            $display("FAIL p1_only: r0=%b r1=%b ce=%b addr=%h, need 0 1 1 005",
                     req0_ready, req1_ready, sram_ce, sram_addr);
        end
        next_window();
    endtask

    task automatic test_back_to_back();
        logic exp_gnt;
        logic prev_gnt;
        logic [BITS-1:0] exp_d;
        drive0(1, 0, 12'h123, 15'h0, 15'h0);
        drive1(1, 0, 12'h005, 15'h0, 15'h0);
        exp_gnt = 1'b0;
        prev_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== (exp_gnt ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL b2b_gnt%0d: r0=%b r1=%b, need port %0d", k, req0_ready, req1_ready, exp_gnt);
            end
            exp_d = prev_gnt ? 15'h7F00 : 15'h5A5A;
            checks++;
            if ({rsp0_valid, rsp1_valid, prev_gnt ? rsp1_rdata : rsp0_rdata}
                !== {~prev_gnt, prev_gnt, exp_d}) begin
                errors++;
                $display("FAIL b2b_rsp%0d: v0=%b v1=%b d0=%h d1=%h, need port %0d data %h",
                         k, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, prev_gnt, exp_d);
            end
            prev_gnt = exp_gnt;
            exp_gnt = ~exp_gnt;
            next_window();
        end
        idle_inputs();
        next_window();
    endtask

    task automatic test_reset_mid_run();
        drive0(1, 0, 12'h123, 15'h0, 15'h0);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_grant: r0=%b, need 1", req0_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0_valid = 1; req0_we = 0;
        req1_valid = 1; req1_we = 0;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, init_done} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_async: v0=%b v1=%b r0=%b r1=%b done=%b, need all 0",
                     rsp0_valid, rsp1_valid, req0_ready, req1_ready, init_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_init("reinit");
        drive0(1, 0, 12'h123, 15'h0, 15'h0);
        drive1(1, 0, 12'h005, 15'h0, 15'h0);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_prio: r0=%b r1=%b, need 1 0", req0_ready, req1_ready);
        end
        next_window();
        drive0(0, 0, 12'h0, 15'h0, 15'h0);
        #1;
        checks++;
        if ({rsp0_valid, rsp0_rdata, req1_ready} !== {1'b1, 15'h0, 1'b1}) begin
            errors++;
            $display("FAIL rst_rd0: v0=%b d0=%h r1=%b, need 1 0000 1", rsp0_valid, rsp0_rdata, req1_ready);
        end
        next_window();
        idle_inputs();
        #1;
        checks++;
        if ({rsp1_valid, rsp1_rdata, rsp0_valid} !== {1'b1, 15'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_rd1: v1=%b d1=%h v0=%b, need 1 0000 0", rsp1_valid, rsp1_rdata, rsp0_valid);
        end
        next_window();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init();
        test_write_read();
        test_masked_write();
        test_port1_only();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
